// File: rtl/wb_burst_mem_ctrl.sv
// Wishbone slave endpoint driving a single-port synchronous memory (1-cycle read latency).
// Supports classic cycles and registered-feedback constant/incrementing bursts with BTE wrapping.
module wb_burst_mem_ctrl #(
  parameter int Dw     = 32,
  parameter int Aw     = 32,
  parameter int SELw   = 4,
  parameter int CTIw   = 3,
  parameter int BTEw   = 2,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [Aw-1:0]     sa_adr_i,
  input  logic [Dw-1:0]     sa_dat_i,
  input  logic [SELw-1:0]   sa_sel_i,
  input  logic              sa_we_i,
  input  logic              sa_cyc_i,
  input  logic              sa_stb_i,
  input  logic [CTIw-1:0]   sa_cti_i,
  input  logic [BTEw-1:0]   sa_bte_i,
  output logic [Dw-1:0]     sa_dat_o,
  output logic              sa_ack_o,
  output logic              sa_err_o,
  output logic              sa_rty_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [SELw-1:0]   mem_be_o,
  output logic [Dw-1:0]     mem_wdat_o,
  input  logic [Dw-1:0]     mem_rdat_i
);

  localparam int SelAw = $clog2(SELw);

  localparam logic [CTIw-1:0] CtiClassic = CTIw'(0);
  localparam logic [CTIw-1:0] CtiConst   = CTIw'(1);
  localparam logic [CTIw-1:0] CtiIncr    = CTIw'(2);
  localparam logic [CTIw-1:0] CtiEnd     = {CTIw{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] beat_adr_q, beat_adr_d;
  logic [MEM_AW-1:0] word_adr, inc_adr, wrap_mask, nxt;
  logic              req, cti_reserved, cti_burst;
  logic              unused_adr_bits;

  assign req          = sa_cyc_i & sa_stb_i;
  assign word_adr     = sa_adr_i[SelAw+MEM_AW-1:SelAw];
  assign cti_burst    = (sa_cti_i == CtiConst) || (sa_cti_i == CtiIncr);
  assign cti_reserved = !((sa_cti_i == CtiClassic) || cti_burst || (sa_cti_i == CtiEnd));
  // Bits above the memory window belong to the bus decoder.
  assign unused_adr_bits = ^{sa_adr_i[Aw-1:SelAw+MEM_AW], sa_adr_i[SelAw-1:0]};

  // Wrapped bursts only advance the low bits selected by the mask.
  always_comb begin
    wrap_mask = {MEM_AW{1'b1}};
    case (sa_bte_i)
      2'b01:   wrap_mask = MEM_AW'(3);
      2'b10:   wrap_mask = MEM_AW'(7);
      2'b11:   wrap_mask = MEM_AW'(15);
      default: wrap_mask = {MEM_AW{1'b1}};
    endcase
  end

  assign inc_adr = beat_adr_q + MEM_AW'(1);
  assign nxt     = (sa_cti_i == CtiConst) ? beat_adr_q
                 : ((beat_adr_q & ~wrap_mask) | (inc_adr & wrap_mask));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_adr_q <= beat_adr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_adr_d = beat_adr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (cti_reserved) begin
            state_d = ERR;
          end else begin
            beat_adr_d = word_adr;
            state_d    = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        // Anything but a continuing burst beat (end, classic, wait state, abort) ends the run.
        if (req && cti_burst) begin
          beat_adr_d = nxt;
        end else begin
          state_d = IDLE;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o = word_adr;
    mem_we_o   = 1'b0;
    mem_be_o   = sa_sel_i;
    mem_wdat_o = sa_dat_i;
    sa_ack_o   = 1'b0;
    sa_err_o   = 1'b0;
    sa_rty_o   = 1'b0;
    sa_dat_o   = '0;
    case (state_q)
      ACTIVE: begin
        sa_ack_o = req;
        if (sa_we_i) begin
          mem_we_o   = req;
          mem_addr_o = beat_adr_q;
        end else begin
          mem_addr_o = nxt;
          if (req) sa_dat_o = mem_rdat_i;
        end
      end
      ERR:     sa_err_o = req;
      default: ;
    endcase
  end

endmodule

// File: doc/wb_burst_mem_ctrl.md
Name: wb_burst_mem_ctrl

Overview:
- Wishbone slave endpoint that sits directly downstream of one slave port of the shared Wishbone bus.
- It consumes that port's adr/dat/sel/we/cyc/stb/cti/bte and returns dat/ack/err/rty.
- It drives a single-port synchronous memory with one-cycle read latency.
- It supports classic cycles plus registered-feedback constant and incrementing bursts, with BTE address wrapping, so a burst sustains one beat per clock.

Parameters:
- Dw, 32, data width.
- Aw, 32, byte address width on the bus.
- SELw, 4, byte-select width (Dw/8).
- CTIw, 3, cycle-type width.
- BTEw, 2, burst-type width.
- MEM_AW, 10, memory word-address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sa_adr_i  in  Aw  byte address from the bus.
- sa_dat_i  in  Dw  write data.
- sa_sel_i  in  SELw  byte selects.
- sa_we_i  in  1  write enable.
- sa_cyc_i  in  1  cycle valid.
- sa_stb_i  in  1  strobe (already qualified by the bus decode).
- sa_cti_i  in  CTIw  cycle type.
- sa_bte_i  in  BTEw  burst type.
- sa_dat_o  out  Dw  read data.
- sa_ack_o  out  1  acknowledge.
- sa_err_o  out  1  error.
- sa_rty_o  out  1  retry; tied 0.
- mem_addr_o  out  MEM_AW  memory word address.
- mem_we_o  out  1  memory write strobe.
- mem_be_o  out  SELw  memory byte enables.
- mem_wdat_o  out  Dw  memory write data.
- mem_rdat_i  in  Dw  memory read data, valid the cycle after its address is driven.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high; ports are named clk and reset.
- Word address: word(a) = a[log2(SELw)+MEM_AW-1 : log2(SELw)]. Upper address bits are ignored; the bus decoder owns them.
- Registers: state {IDLE, ACTIVE, ERR}; beat_adr[MEM_AW-1:0].
- Reset state: state=IDLE, beat_adr=0. Outputs are decoded from state, so ack, err and mem_we are 0 and sa_dat_o=0 immediately on reset assertion, including mid-burst.
- req = sa_cyc_i & sa_stb_i.
- CTI values:
  - Valid: 000 classic, 001 constant-address burst, 010 incrementing burst, 111 end-of-burst.
  - Reserved: 011..110.
- IDLE:
  - mem_addr_o = word(sa_adr_i); mem_we_o=0; ack=0; err=0.
  - On req with reserved CTI: go to ERR.
  - On req otherwise: beat_adr <= word(sa_adr_i); go to ACTIVE. This is a read prefetch for reads and harmless for writes.
- ACTIVE:
  - sa_ack_o = req.
  - Write: mem_we_o = req & sa_we_i, mem_addr_o = beat_adr, mem_be_o = sa_sel_i, mem_wdat_o = sa_dat_i.
  - Read: sa_dat_o = mem_rdat_i, mem_addr_o = nxt (prefetch of the next beat).
  - sa_dat_o = 0 whenever there is no read ack.
- Next address nxt:
  - cti 001: nxt = beat_adr.
  - cti 010: nxt = beat_adr+1, wrapped per BTE.
  - BTE 00: linear, modulo 2^MEM_AW.
  - BTE 01/10/11: only the low 2/3/4 bits increment modulo 4/8/16; upper bits are held.
- ACTIVE transitions:
  - req with cti 001 or 010: beat_adr <= nxt; stay in ACTIVE.
  - req with cti 000 or 111: go to IDLE, giving one bubble before the next request.
  - cyc=1, stb=0 (master wait state): no ack; go to IDLE. The resume is refetched from the presented address, costing one bubble.
  - cyc=0 (abort): go to IDLE; no ack, no write.
- ERR: sa_err_o = req for this one cycle; no ack; no memory write; then go to IDLE.
- Latency:
  - First ack arrives 1 cycle after req appears in IDLE.
  - Bursts then ack every cycle.
  - Classic cycles complete one per 2 cycles.
- Ack and err are never asserted together.

Test Plan:
- Classic read, sa_adr_i=0x10, cti=000; memory word4 = 0xA5A5_0004 -> cycle0: mem_addr_o=4, no ack; cycle1: ack=1, sa_dat_o=0xA5A5_0004; cycle2: ack=0.
- Incrementing read, start word6, bte=01, cti=010,010,010,111 -> mem_addr_o sequence 6,7,4,5 (then a prefetch); acks on 4 consecutive cycles returning the words at addresses 6,7,4,5; state returns to IDLE.
- Linear write burst from word 1023 (MEM_AW=10), 3 beats, sel=4'b0011 -> mem_we_o at addresses 1023,0,1 with mem_be_o=0011 and matching data; no fourth write.
- Reserved cti=011 on a request -> sa_err_o=1 for exactly one cycle the cycle after req; sa_ack_o=0 and mem_we_o=0 throughout.
- Read burst with stb held low for 2 cycles after beat 1 while cyc stays high -> no ack during the stall; on resume 1 bubble cycle, then the correct data for the presented address.
- reset asserted in the middle of a 4-beat burst -> sa_ack_o and mem_we_o drop in the same cycle; after release the block is in IDLE and a new classic read completes normally.
